// File: rtl/id_ex_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage_reg
// Brief    : LC-3b ID/EX pipeline register with load-use interlock.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_stage_reg #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_in,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [3:0]       id_opcode,
  input  logic [2:0]       id_sr1,
  input  logic [2:0]       id_sr2,
  input  logic             id_uses_sr1,
  input  logic             id_uses_sr2,
  input  logic [2:0]       id_dest,
  input  logic             id_regwrite,
  input  logic [15:0]      id_sr1_data,
  input  logic [15:0]      id_sr2_data,
  input  logic [15:0]      id_pc,
  input  logic [15:0]      id_imm,
  output logic             ex_valid,
  output logic [3:0]       ex_opcode,
  output logic [2:0]       ex_sr1,
  output logic [2:0]       ex_sr2,
  output logic [2:0]       ex_dest,
  output logic             ex_regwrite,
  output logic [15:0]      ex_sr1_data,
  output logic [15:0]      ex_sr2_data,
  output logic [15:0]      ex_pc,
  output logic [15:0]      ex_imm,
  output logic             stall_if_id,
  output logic [CNT_W-1:0] bubble_count
);

  localparam logic [3:0] C_OP_BR  = 4'b0000;
  localparam logic [3:0] C_OP_LDB = 4'b0010;
  localparam logic [3:0] C_OP_LDR = 4'b0110;
  localparam logic [3:0] C_OP_LDI = 4'b1010;
  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             r_valid;
  logic [3:0]       r_opcode;
  logic [2:0]       r_sr1;
  logic [2:0]       r_sr2;
  logic [2:0]       r_dest;
  logic             r_regwrite;
  logic [15:0]      r_sr1_data;
  logic [15:0]      r_sr2_data;
  logic [15:0]      r_pc;
  logic [15:0]      r_imm;
  logic [CNT_W-1:0] r_bubble_count;

  logic w_ex_is_load;
  logic w_src_hit;
  logic w_hazard;

  // Loads deliver data only at the end of MEM, so a consumer directly behind
  // one must wait a cycle; R0 is an ordinary register here.
  assign w_ex_is_load = (r_opcode == C_OP_LDR) || (r_opcode == C_OP_LDB) ||
                        (r_opcode == C_OP_LDI);
  assign w_src_hit    = (id_uses_sr1 && (id_sr1 == r_dest)) ||
                        (id_uses_sr2 && (id_sr2 == r_dest));
  assign w_hazard     = r_valid && r_regwrite && w_ex_is_load && id_valid && w_src_hit;
  assign stall_if_id  = w_hazard && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid        <= 1'b0;
      r_opcode       <= C_OP_BR;
      r_sr1          <= 3'd0;
      r_sr2          <= 3'd0;
      r_dest         <= 3'd0;
      r_regwrite     <= 1'b0;
      r_sr1_data     <= 16'd0;
      r_sr2_data     <= 16'd0;
      r_pc           <= 16'd0;
      r_imm          <= 16'd0;
      r_bubble_count <= '0;
    end else if (stall_in) begin
      r_valid        <= r_valid;
    end else if (flush || w_hazard) begin
      r_valid    <= 1'b0;
      r_opcode   <= C_OP_BR;
      r_sr1      <= 3'd0;
      r_sr2      <= 3'd0;
      r_dest     <= 3'd0;
      r_regwrite <= 1'b0;
      r_sr1_data <= 16'd0;
      r_sr2_data <= 16'd0;
      r_pc       <= 16'd0;
      r_imm      <= 16'd0;
      // Only interlock bubbles are counted; redirects are not stalls.
      if (!flush && (r_bubble_count != {CNT_W{1'b1}}))
        r_bubble_count <= r_bubble_count + C_CNT_ONE;
    end else begin
      r_valid    <= id_valid;
      r_opcode   <= id_opcode;
      r_sr1      <= id_sr1;
      r_sr2      <= id_sr2;
      r_dest     <= id_dest;
      r_regwrite <= id_regwrite && id_valid;
      r_sr1_data <= id_sr1_data;
      r_sr2_data <= id_sr2_data;
      r_pc       <= id_pc;
      r_imm      <= id_imm;
    end
  end

  assign ex_valid     = r_valid;
  assign ex_opcode    = r_opcode;
  assign ex_sr1       = r_sr1;
  assign ex_sr2       = r_sr2;
  assign ex_dest      = r_dest;
  assign ex_regwrite  = r_regwrite;
  assign ex_sr1_data  = r_sr1_data;
  assign ex_sr2_data  = r_sr2_data;
  assign ex_pc        = r_pc;
  assign ex_imm       = r_imm;
  assign bubble_count = r_bubble_count;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_stage_reg
// Brief    : Directed self-checking bench for id_ex_stage_reg (CNT_W = 2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage_reg;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst, stall_in, flush;
  logic             id_valid, id_uses_sr1, id_uses_sr2, id_regwrite;
  logic [3:0]       id_opcode;
  logic [2:0]       id_sr1, id_sr2, id_dest;
  logic [15:0]      id_sr1_data, id_sr2_data, id_pc, id_imm;
  logic             ex_valid, ex_regwrite, stall_if_id;
  logic [3:0]       ex_opcode;
  logic [2:0]       ex_sr1, ex_sr2, ex_dest;
  logic [15:0]      ex_sr1_data, ex_sr2_data, ex_pc, ex_imm;
  logic [CNT_W-1:0] bubble_count;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  id_ex_stage_reg #(.CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst), .stall_in(stall_in), .flush(flush),
    .id_valid(id_valid), .id_opcode(id_opcode), .id_sr1(id_sr1), .id_sr2(id_sr2),
    .id_uses_sr1(id_uses_sr1), .id_uses_sr2(id_uses_sr2), .id_dest(id_dest),
    .id_regwrite(id_regwrite), .id_sr1_data(id_sr1_data), .id_sr2_data(id_sr2_data),
    .id_pc(id_pc), .id_imm(id_imm),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_sr1(ex_sr1), .ex_sr2(ex_sr2),
    .ex_dest(ex_dest), .ex_regwrite(ex_regwrite), .ex_sr1_data(ex_sr1_data),
    .ex_sr2_data(ex_sr2_data), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .stall_if_id(stall_if_id), .bubble_count(bubble_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic set_id(input logic v, input logic [3:0] op, input logic [2:0] s1,
                        input logic [2:0] s2, input logic u1, input logic u2,
                        input logic [2:0] d, input logic rw, input logic [15:0] d1,
                        input logic [15:0] d2, input logic [15:0] pc);
    id_valid = v; id_opcode = op; id_sr1 = s1; id_sr2 = s2;
    id_uses_sr1 = u1; id_uses_sr2 = u2; id_dest = d; id_regwrite = rw;
    id_sr1_data = d1; id_sr2_data = d2; id_pc = pc; id_imm = pc ^ 16'h00FF;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // LDR R4 <- [R2]
  task automatic put_ldr_r4();
    set_id(1'b1, 4'h6, 3'd2, 3'd0, 1'b1, 1'b0, 3'd4, 1'b1, 16'h1111, 16'h0, 16'h3100);
  endtask

  initial begin
    rst = 1'b1; stall_in = 1'b0; flush = 1'b0;
    set_id(1'b1, 4'(($urandom)), 3'($urandom), 3'($urandom), 1'b1, 1'b1,
           3'($urandom), 1'b1, 16'($urandom), 16'($urandom), 16'($urandom));
    tick();
    set_id(1'b1, 4'h6, 3'($urandom), 3'($urandom), 1'b1, 1'b1,
           3'($urandom), 1'b1, 16'($urandom), 16'($urandom), 16'($urandom));
    tick();
    chk("rst_valid", 32'(ex_valid), 0);
    chk("rst_regwrite", 32'(ex_regwrite), 0);
    chk("rst_bubbles", 32'(bubble_count), 0);
    chk("rst_opcode", 32'(ex_opcode), 0);
    chk("rst_sr1_data", 32'(ex_sr1_data), 0);
    chk("rst_pc", 32'(ex_pc), 0);
    rst = 1'b0;

    // ADD R1,R2,R3
    set_id(1'b1, 4'h1, 3'd2, 3'd3, 1'b1, 1'b1, 3'd1, 1'b1, 16'h0005, 16'h0007, 16'h3000);
    chk("pass_stall", 32'(stall_if_id), 0);
    tick();
    chk("pass_valid", 32'(ex_valid), 1);
    chk("pass_dest", 32'(ex_dest), 1);
    chk("pass_sr1_data", 32'(ex_sr1_data), 32'h0005);
    chk("pass_pc", 32'(ex_pc), 32'h3000);
    chk("pass_imm", 32'(ex_imm), 32'h30FF);

    // Load-use on sr1: LDR R4, then ADD R5,R4,R1
    put_ldr_r4();
    chk("ldr_in_id_stall", 32'(stall_if_id), 0);
    tick();
    set_id(1'b1, 4'h1, 3'd4, 3'd1, 1'b1, 1'b1, 3'd5, 1'b1, 16'hAAAA, 16'hBBBB, 16'h3102);
    chk("lu1_stall", 32'(stall_if_id), 1);
    tick();
    chk("lu1_bubble_valid", 32'(ex_valid), 0);
    chk("lu1_bubble_rw", 32'(ex_regwrite), 0);
    chk("lu1_count", 32'(bubble_count), 1);
    chk("lu1_stall_clears", 32'(stall_if_id), 0);
    tick();
    chk("lu1_consumer_valid", 32'(ex_valid), 1);
    chk("lu1_consumer_dest", 32'(ex_dest), 5);
    chk("lu1_consumer_pc", 32'(ex_pc), 32'h3102);

    // Load-use on sr2: ADD R5,R1,R4
    put_ldr_r4();
    tick();
    set_id(1'b1, 4'h1, 3'd1, 3'd4, 1'b1, 1'b1, 3'd5, 1'b1, 16'h0, 16'h0, 16'h3104);
    chk("lu2_stall", 32'(stall_if_id), 1);
    tick();
    chk("lu2_bubble_valid", 32'(ex_valid), 0);
    chk("lu2_count", 32'(bubble_count), 2);
    tick();
    chk("lu2_consumer_pc", 32'(ex_pc), 32'h3104);

    // Flush beats hazard
    put_ldr_r4();
    tick();
    set_id(1'b1, 4'h1, 3'd4, 3'd1, 1'b1, 1'b1, 3'd5, 1'b1, 16'h0, 16'h0, 16'h3106);
    flush = 1'b1;
    #1;
    chk("flush_stall", 32'(stall_if_id), 0);
    tick();
    flush = 1'b0;
    chk("flush_valid", 32'(ex_valid), 0);
    chk("flush_count", 32'(bubble_count), 2);

    // Downstream stall freezes everything, even with flush and a hazard pending
    put_ldr_r4();
    tick();
    stall_in = 1'b1; flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(1'b1, 4'h1, 3'd4, 3'd4, 1'b1, 1'b1, 3'(i), 1'b1, 16'(i), 16'(i), 16'h4000 + 16'(i));
      tick();
    end
    chk("hold_valid", 32'(ex_valid), 1);
    chk("hold_opcode", 32'(ex_opcode), 6);
    chk("hold_pc", 32'(ex_pc), 32'h3100);
    chk("hold_count", 32'(bubble_count), 2);
    stall_in = 1'b0; flush = 1'b0;
    // ID no longer depends on R4, so the next edge captures it
    set_id(1'b1, 4'h5, 3'd1, 3'd2, 1'b1, 1'b1, 3'd6, 1'b1, 16'h5555, 16'h6666, 16'h5000);
    tick();
    chk("release_pc", 32'(ex_pc), 32'h5000);
    chk("release_sr2_data", 32'(ex_sr2_data), 32'h6666);

    // Invalid ID instruction never sets ex_regwrite
    set_id(1'b0, 4'h1, 3'd1, 3'd2, 1'b1, 1'b1, 3'd3, 1'b1, 16'h0, 16'h0, 16'h5002);
    tick();
    chk("inval_valid", 32'(ex_valid), 0);
    chk("inval_regwrite", 32'(ex_regwrite), 0);

    // Load in EX but ID slot empty: no interlock
    put_ldr_r4();
    tick();
    set_id(1'b0, 4'h1, 3'd4, 3'd4, 1'b1, 1'b1, 3'd5, 1'b1, 16'h0, 16'h0, 16'h5004);
    chk("idinval_nostall", 32'(stall_if_id), 0);

    // R0 is an ordinary register: LDB R0 then STR reading R0 as store source
    set_id(1'b1, 4'h2, 3'd3, 3'd0, 1'b1, 1'b0, 3'd0, 1'b1, 16'h0, 16'h0, 16'h5006);
    tick();
    set_id(1'b1, 4'h7, 3'd1, 3'd0, 1'b1, 1'b1, 3'd0, 1'b0, 16'h0, 16'h0, 16'h5008);
    chk("r0_stall", 32'(stall_if_id), 1);
    tick();
    chk("sat_count_3", 32'(bubble_count), 3);
    tick();

    // Another hazard with the counter at all-ones: no wrap (LDI R2, then use R2)
    set_id(1'b1, 4'hA, 3'd0, 3'd0, 1'b0, 1'b0, 3'd2, 1'b1, 16'h0, 16'h0, 16'h500A);
    tick();
    set_id(1'b1, 4'h1, 3'd2, 3'd0, 1'b1, 1'b0, 3'd3, 1'b1, 16'h0, 16'h0, 16'h500C);
    chk("ldi_stall", 32'(stall_if_id), 1);
    tick();
    chk("sat_hold", 32'(bubble_count), 3);
    chk("sat_bubble", 32'(ex_valid), 0);
    tick();

    // Reset asserted mid-stall wins
    put_ldr_r4();
    tick();
    set_id(1'b1, 4'h1, 3'd4, 3'd1, 1'b1, 1'b1, 3'd5, 1'b1, 16'h0, 16'h0, 16'h600E);
    chk("mid_stall_pre", 32'(stall_if_id), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(ex_valid), 0);
    chk("mid_rst_stall", 32'(stall_if_id), 0);
    chk("mid_rst_count", 32'(bubble_count), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register for the LC-3b pipeline, with an integrated load-use interlock.
- Captures the decoded instruction and its register-file operands at the end of ID, and presents them to EX.
- Drives the EX-stage fields (regwrite, dest, opcode, source register numbers) that the operand-forwarding logic consumes.
- Detects load-use hazards that forwarding cannot cover; on a hazard it stalls IF/ID and injects a bubble.

Parameters:
- CNT_W, 16, width of the saturating bubble counter.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall_in  in  1  downstream (MEM) stall; freeze this register.
- flush  in  1  branch/jump/trap redirect; discard the ID instruction.
- id_valid  in  1  ID holds a real instruction.
- id_opcode  in  4  lc3b_opcode of the ID instruction.
- id_sr1  in  3  lc3b_reg, source 1 number.
- id_sr2  in  3  lc3b_reg, source 2 number.
- id_uses_sr1  in  1  ID instruction reads sr1.
- id_uses_sr2  in  1  ID instruction reads sr2 (includes store source).
- id_dest  in  3  lc3b_reg, destination number.
- id_regwrite  in  1  ID instruction writes the register file.
- id_sr1_data  in  16  lc3b_word from the register file.
- id_sr2_data  in  16  lc3b_word from the register file.
- id_pc  in  16  PC of the ID instruction.
- id_imm  in  16  sign-extended immediate/offset.
- ex_valid  out  1  EX holds a real instruction.
- ex_opcode  out  4  registered opcode.
- ex_sr1, ex_sr2  out  3 each  registered source numbers.
- ex_dest  out  3  registered destination.
- ex_regwrite  out  1  registered regwrite, gated by valid.
- ex_sr1_data, ex_sr2_data  out  16 each  registered operands.
- ex_pc, ex_imm  out  16 each  registered PC and immediate.
- stall_if_id  out  1  freeze PC and IF/ID (combinational).
- bubble_count  out  CNT_W  saturating count of load-use bubbles.

Behaviour:
- Load-use hazard (combinational) is the AND of:
  - ex_valid & ex_regwrite;
  - ex_opcode in {op_ldr, op_ldb, op_ldi};
  - id_valid;
  - (id_uses_sr1 & id_sr1==ex_dest) | (id_uses_sr2 & id_sr2==ex_dest).
- R0 is treated as an ordinary register; a match on R0 stalls.
- stall_if_id = hazard & ~flush.
  - stall_in does not gate it; upstream ORs in stall_in itself.
- Register update priority each rising edge (highest first):
  1. rst: clear every output register to 0. ex_valid=0, ex_regwrite=0, ex_opcode=op_br (encoding 0), bubble_count=0.
  2. stall_in: hold all registers and bubble_count unchanged, even if flush or hazard is asserted.
  3. flush: load a bubble (ex_valid=0, ex_regwrite=0; other fields don't-care, cleared to 0). bubble_count unchanged.
  4. hazard: load a bubble; bubble_count += 1, saturating at all-ones.
  5. otherwise: capture all id_* fields.
     - ex_valid=id_valid.
     - ex_regwrite=id_regwrite & id_valid.
- Latency: an instruction presented in ID at cycle N appears on ex_* in cycle N+1, absent stall/flush/hazard.
- A hazard always lasts exactly one cycle for a single load:
  - After the bubble, EX holds no load, so the hazard clears.
  - The consumer enters EX at N+2 and the load is then in MEM, where forwarding covers it.
- Back-to-back loads each feeding the next: every dependent instruction incurs exactly one bubble.
- Reset asserted mid-stall: reset wins; the next cycle shows ex_valid=0 and stall_if_id reflects only current inputs.
- ex_regwrite is never 1 while ex_valid is 0.

Test Plan:
- Reset: assert rst for 2 cycles with random inputs -> ex_valid=0, ex_regwrite=0, bubble_count=0, all data outputs 0.
- Pass-through: ADD R1,R2,R3 (id_pc=0x3000, id_sr1_data=0x0005), no hazards -> next cycle ex_valid=1, ex_dest=1, ex_sr1_data=0x0005, ex_pc=0x3000; stall_if_id=0 throughout.
- Load-use: LDR R4 into EX, then ADD R5,R4,R1 in ID:
  - -> stall_if_id=1 for one cycle;
  - -> EX shows a bubble (ex_valid=0);
  - -> bubble_count=1;
  - -> ADD enters EX on the following cycle.
  - Repeat with R4 as id_sr2 -> same.
- Flush beats hazard: same load-use pair with flush=1 in the hazard cycle -> stall_if_id=0, bubble inserted, bubble_count unchanged.
- Downstream stall: stall_in=1 for 3 cycles with changing id_* inputs and flush=1 -> all ex_* and bubble_count frozen. After release, the next edge captures current ID.
- Saturation: preload by forcing 0xFFFE hazards (or set CNT_W=2 and run 5 hazards) -> counter stops at all-ones (3 for CNT_W=2) without wrapping.
